// File: rtl/dsram_store_buffer_pkg.sv
// Shared types and helpers for the data-SRAM store buffer.
//   sb_entry_t    : one store-buffer slot (valid, word index, byte enables, data)
//   drain_state_t : drain FSM states
//   merge_bytes   : byte-lane merge of new data over a base word
package dsram_store_buffer_pkg;

  localparam int WORD_BYTES = 4;

  // Word-index field is sized for the largest possible ADDR_W (32-bit byte
  // address minus the two byte-offset bits); narrower configurations keep the
  // upper bits at zero so full-width compares stay exact.
  localparam int MAX_IDX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] word_idx;
    logic [3:0]           wen;
    logic [31:0]          data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RMW_WAIT,
    RMW_WR
  } drain_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [3:0]  wen,
                                              input logic [31:0] data);
    logic [31:0] merged;
    merged = base;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (wen[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dsram_sp_ram.sv
// Single-port synchronous word RAM, 1-cycle read latency, no reset.
//   clk   : clock
//   en    : port access this cycle
//   we    : 1 = write wdata to addr, 0 = read addr (q valid next cycle)
//   addr  : word index
//   wdata : write data
//   q     : read data; holds its value on writes and idle cycles
module dsram_sp_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/dsram_store_buffer.sv
// MEM-stage data_sram responder with a FIFO store buffer.
// Loads complete with 1-cycle latency, forwarding bytes from pending stores
// (newest wins). Stores are posted into the buffer and drained into a
// word-granular single-port RAM; partial stores drain as read-modify-write.
// Optional feature macro: DSRAM_SB_COALESCE_EN (a store to the same word as
// the newest entry merges into it instead of allocating).
//   clk, rst_n      : clock, synchronous active-low reset
//   data_sram_en    : request valid
//   data_sram_wen   : byte write enables, 0 = load
//   data_sram_addr  : byte address (bits [1:0] ignored)
//   data_sram_wdata : store data
//   data_sram_rdata : load data, valid the cycle after the load
//   ds_stall        : buffer full
//   sb_empty        : no pending stores
//   sb_overflow     : sticky, a store was dropped
module dsram_store_buffer
  import dsram_store_buffer_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        ds_stall,
  output logic        sb_empty,
  output logic        sb_overflow
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          sb [SB_DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  drain_state_t       state, state_nxt;
  logic [31:0]        merge_q, merge_nxt;
  logic               overflow_q;

  logic               load_q;
  logic [3:0]         fwd_mask, fwd_mask_q;
  logic [31:0]        fwd_data, fwd_data_q;

  logic               ram_en, ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [31:0]        ram_wdata, ram_q;

  logic [MAX_IDX_W-1:0] req_idx;
  logic               is_load, is_store, port_free, full;
  logic               pop, push, drop, coalesce;
  sb_entry_t          head_e;
  logic               unused_addr;

  assign req_idx     = MAX_IDX_W'(data_sram_addr[ADDR_W+1:2]);
  assign unused_addr = ^data_sram_addr;
  assign is_load     = data_sram_en && (data_sram_wen == 4'h0);
  assign is_store    = data_sram_en && (data_sram_wen != 4'h0);
  assign port_free   = !is_load;
  assign full        = (count == CNT_W'(SB_DEPTH));
  assign head_e      = sb[head];

  assign ds_stall    = full;
  assign sb_empty    = (count == '0);
  assign sb_overflow = overflow_q;

  dsram_sp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // A load always takes the RAM port; the drain only touches the port when it
  // is free. RMW_WAIT needs no port, so a load there does not delay the drain.
  always_comb begin
    state_nxt = state;
    merge_nxt = merge_q;
    pop       = 1'b0;
    ram_en    = is_load;
    ram_we    = 1'b0;
    ram_addr  = req_idx[ADDR_W-1:0];
    ram_wdata = merge_q;
    unique case (state)
      IDLE: begin
        if (count != '0 && port_free) begin
          ram_en   = 1'b1;
          ram_addr = head_e.word_idx[ADDR_W-1:0];
          if (head_e.wen == 4'hF) begin
            ram_we    = 1'b1;
            ram_wdata = head_e.data;
            pop       = 1'b1;
          end else begin
            state_nxt = RMW_WAIT;
          end
        end
      end
      RMW_WAIT: begin
        merge_nxt = merge_bytes(ram_q, head_e.wen, head_e.data);
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        if (port_free) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = head_e.word_idx[ADDR_W-1:0];
          ram_wdata = merge_q;
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Walk entries oldest to newest so later stores overwrite earlier bytes.
  always_comb begin
    fwd_mask = 4'h0;
    fwd_data = 32'h0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      logic [PTR_W-1:0] ptr;
      ptr = head + PTR_W'(i);
      if (sb[ptr].valid && sb[ptr].word_idx == req_idx) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (sb[ptr].wen[b]) begin
            fwd_mask[b]       = 1'b1;
            fwd_data[8*b +: 8] = sb[ptr].data[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef DSRAM_SB_COALESCE_EN
  logic [PTR_W-1:0] newest;
  assign newest   = tail - 1'b1;
  // The head cannot absorb a store once its RMW has started or while it pops.
  assign coalesce = is_store && (count != '0) && sb[newest].valid &&
                    (sb[newest].word_idx == req_idx) &&
                    !((newest == head) && (state != IDLE || pop));
`else
  assign coalesce = 1'b0;
`endif

  assign push = is_store && !coalesce && (!full || pop);
  assign drop = is_store && !coalesce && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= IDLE;
      merge_q    <= 32'h0;
      overflow_q <= 1'b0;
      load_q     <= 1'b0;
      fwd_mask_q <= 4'h0;
      fwd_data_q <= 32'h0;
    end else begin
      state      <= state_nxt;
      merge_q    <= merge_nxt;
      load_q     <= is_load;
      fwd_mask_q <= fwd_mask;
      fwd_data_q <= fwd_data;
      if (pop) begin
        sb[head].valid <= 1'b0;
        head           <= head + 1'b1;
      end
      // When full, push and pop share the same slot; the push must win.
      if (push) begin
        sb[tail] <= '{valid: 1'b1, word_idx: req_idx,
                      wen: data_sram_wen, data: data_sram_wdata};
        tail     <= tail + 1'b1;
      end
`ifdef DSRAM_SB_COALESCE_EN
      if (coalesce) begin
        sb[newest].wen  <= sb[newest].wen | data_sram_wen;
        sb[newest].data <= merge_bytes(sb[newest].data, data_sram_wen,
                                       data_sram_wdata);
      end
`endif
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Load data: forwarded bytes override the RAM word read in the load cycle.
  always_comb begin
    data_sram_rdata = 32'h0;
    if (load_q) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        data_sram_rdata[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8]
                                                  : ram_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dsram_store_buffer.sv
// Self-checking bench for dsram_store_buffer. Load responses are checked by a
// scoreboard monitor; status outputs are checked directly by checkOutput.
module tb_dsram_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        ds_stall, sb_empty, sb_overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic        load_seen = 1'b0;

  always #5 clk = ~clk;

  dsram_store_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .ds_stall        (ds_stall),
    .sb_empty        (sb_empty),
    .sb_overflow     (sb_overflow)
  );

  // Track which cycles carried a load so the monitor knows when rdata is due.
  always @(posedge clk)
    load_seen <= rst_n && data_sram_en && (data_sram_wen == 4'h0);

  // Scoreboard monitor: compare rdata against the oldest expected response.
  always @(negedge clk) begin
    if (load_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rdata_unexpected: got %08h, required no response", data_sram_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_sram_rdata !== e) begin
          errors++;
          $display("[TB] FAIL rdata: got %08h, required %08h", data_sram_rdata, e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic en_i, input logic [3:0] wen_i,
                               input logic [31:0] addr_i, input logic [31:0] wdata_i);
    data_sram_en    = en_i;
    data_sram_wen   = wen_i;
    data_sram_addr  = addr_i;
    data_sram_wdata = wdata_i;
    @(posedge clk);
    #1;
  endtask

  task automatic storeWord(input logic [31:0] addr_i, input logic [3:0] wen_i,
                           input logic [31:0] data_i);
    applyStimulus(1'b1, wen_i, addr_i, data_i);
  endtask

  task automatic loadWord(input logic [31:0] addr_i, input logic [31:0] expv);
    exp_q.push_back(expv);
    applyStimulus(1'b1, 4'h0, addr_i, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdata", data_sram_rdata, 32'h0);
    checkOutput("reset_stall", {31'h0, ds_stall}, 32'h0);
    checkOutput("reset_empty", {31'h0, sb_empty}, 32'h1);
    checkOutput("reset_overflow", {31'h0, sb_overflow}, 32'h0);
    rst_n = 1'b1;

    $display("[TB] full-word store then load");
    storeWord(32'h1000, 4'hF, 32'hDEADBEEF);
    idle(1);
    checkOutput("full_store_drained", {31'h0, sb_empty}, 32'h1);
    loadWord(32'h1000, 32'hDEADBEEF);

    $display("[TB] preload words");
    storeWord(32'h0040, 4'hF, 32'h11223344);
    storeWord(32'h0200, 4'hF, 32'h01020304);
    storeWord(32'h0300, 4'hF, 32'hA0B0C0D0);
    storeWord(32'h0400, 4'hF, 32'h11111111);
    storeWord(32'h0404, 4'hF, 32'h22222222);
    storeWord(32'h0408, 4'hF, 32'h33333333);
    storeWord(32'h040C, 4'hF, 32'h44444444);
    storeWord(32'h0410, 4'hF, 32'h55555555);
    idle(1);
    checkOutput("preload_drained", {31'h0, sb_empty}, 32'h1);

    $display("[TB] partial store forwarding");
    storeWord(32'h0040, 4'b0010, 32'h0000AA00);
    loadWord(32'h0040, 32'h1122AA44);
    idle(3);
    checkOutput("rmw_drained", {31'h0, sb_empty}, 32'h1);
    loadWord(32'h0040, 32'h1122AA44);

    $display("[TB] same-word stores, newest wins");
    storeWord(32'h0200, 4'b0001, 32'h000000AA);
    storeWord(32'h0200, 4'b0001, 32'h000000BB);
    loadWord(32'h0200, 32'h010203BB);
    idle(4);
    checkOutput("same_word_drained", {31'h0, sb_empty}, 32'h1);
    loadWord(32'h0200, 32'h010203BB);

    $display("[TB] load during RMW_WR");
    storeWord(32'h0300, 4'b1000, 32'h55000000);
    idle(2);
    loadWord(32'h0300, 32'h55B0C0D0);
    checkOutput("write_deferred", {31'h0, sb_empty}, 32'h0);
    idle(1);
    checkOutput("deferred_pop", {31'h0, sb_empty}, 32'h1);
    loadWord(32'h0300, 32'h55B0C0D0);

    $display("[TB] fill buffer, overflow, back-to-back loads");
    storeWord(32'h0400, 4'b0001, 32'h000000A1);
    storeWord(32'h0404, 4'b0010, 32'h0000B200);
    storeWord(32'h0408, 4'b0100, 32'h00C30000);
    storeWord(32'h040C, 4'b1000, 32'hD4000000);
    storeWord(32'h0410, 4'b0011, 32'h0000E5E5);
    checkOutput("no_overflow_yet", {31'h0, sb_overflow}, 32'h0);
    storeWord(32'h0400, 4'hF, 32'hFFFFFFFF);
    checkOutput("full_stall", {31'h0, ds_stall}, 32'h1);
    checkOutput("overflow_set", {31'h0, sb_overflow}, 32'h1);
    loadWord(32'h0400, 32'h111111A1);
    loadWord(32'h0404, 32'h2222B222);
    loadWord(32'h0408, 32'h33C33333);
    loadWord(32'h040C, 32'hD4444444);
    loadWord(32'h0410, 32'h5555E5E5);
    checkOutput("stall_during_loads", {31'h0, ds_stall}, 32'h1);
    cyc = 0;
    while (!sb_empty && cyc < 40) begin
      idle(1);
      cyc++;
    end
    checkOutput("buffer_drained", {31'h0, sb_empty}, 32'h1);
    checkOutput("stall_released", {31'h0, ds_stall}, 32'h0);
    checkOutput("overflow_sticky", {31'h0, sb_overflow}, 32'h1);
    loadWord(32'h0400, 32'h111111A1);
    loadWord(32'h0404, 32'h2222B222);
    loadWord(32'h0408, 32'h33C33333);
    loadWord(32'h040C, 32'hD4444444);
    loadWord(32'h0410, 32'h5555E5E5);

    $display("[TB] reset with pending entries");
    storeWord(32'h0600, 4'b0001, 32'h00000001);
    storeWord(32'h0604, 4'b0001, 32'h00000002);
    storeWord(32'h0608, 4'b0001, 32'h00000003);
    loadWord(32'h1000, 32'hDEADBEEF);
    checkOutput("pending_before_reset", {31'h0, sb_empty}, 32'h0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    checkOutput("post_reset_empty", {31'h0, sb_empty}, 32'h1);
    checkOutput("post_reset_stall", {31'h0, ds_stall}, 32'h0);
    checkOutput("post_reset_rdata", data_sram_rdata, 32'h0);
    checkOutput("post_reset_overflow", {31'h0, sb_overflow}, 32'h0);
    loadWord(32'h1000, 32'hDEADBEEF);
    idle(2);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
